// File: rtl/resize_grid_scheduler.sv
// Walks the resize target grid in raster order and issues one command per target pixel.
// Source anchors and fractional remainders follow a DDA whose steps come from a serial divider.
module resize_grid_scheduler #(
    parameter int COORD_W = 7,
    parameter int TADDR_W = 12
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               start,
    input  logic [COORD_W-1:0] H0,
    input  logic [COORD_W-1:0] V0,
    input  logic [4:0]         SW,
    input  logic [4:0]         SH,
    input  logic [5:0]         TW,
    input  logic [5:0]         TH,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [COORD_W-1:0] src_col,
    output logic [COORD_W-1:0] src_row,
    output logic [5:0]         frac_h,
    output logic [5:0]         frac_v,
    output logic [TADDR_W-1:0] tgt_addr,
    output logic               row_first,
    output logic               row_last,
    output logic               busy,
    output logic               done,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PREP  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [COORD_W-1:0] r_h0;
    logic [COORD_W-1:0] r_v0;
    logic [5:0]         r_dh;
    logic [5:0]         r_dv;
    logic [4:0]         r_step_q_h;
    logic [4:0]         r_step_q_v;
    logic [5:0]         r_step_r_h;
    logic [5:0]         r_step_r_v;
    logic [COORD_W-1:0] r_quot_h;
    logic [COORD_W-1:0] r_quot_v;
    logic [5:0]         r_rem_h;
    logic [5:0]         r_rem_v;
    logic [5:0]         r_col;
    logic [5:0]         r_row;
    logic [TADDR_W-1:0] r_addr;

    logic       w_fin_h;
    logic       w_fin_v;
    logic       w_hs;
    logic       w_last_col;
    logic       w_last_row;
    logic [6:0] w_sum_h;
    logic [6:0] w_sum_v;
    logic       w_wrap_h;
    logic       w_wrap_v;
    logic [5:0] w_rem_h_nxt;
    logic [5:0] w_rem_v_nxt;

    // A zero divisor (single-pixel target axis) has nothing to divide.
    assign w_fin_h = (r_dh == 6'd0) || (r_step_r_h < r_dh);
    assign w_fin_v = (r_dv == 6'd0) || (r_step_r_v < r_dv);

    assign w_hs       = cmd_valid && cmd_ready;
    assign w_last_col = (r_col == r_dh);
    assign w_last_row = (r_row == r_dv);

    // Remainders stay below the divisor, so the 6-bit modular result is exact.
    assign w_sum_h     = {1'b0, r_rem_h} + {1'b0, r_step_r_h};
    assign w_sum_v     = {1'b0, r_rem_v} + {1'b0, r_step_r_v};
    assign w_wrap_h    = (w_sum_h >= {1'b0, r_dh});
    assign w_wrap_v    = (w_sum_v >= {1'b0, r_dv});
    assign w_rem_h_nxt = w_wrap_h ? (r_rem_h + r_step_r_h - r_dh) : (r_rem_h + r_step_r_h);
    assign w_rem_v_nxt = w_wrap_v ? (r_rem_v + r_step_r_v - r_dv) : (r_rem_v + r_step_r_v);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_PREP;
            end
            S_PREP: begin
                busy = 1'b1;
                if (w_fin_h && w_fin_v) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                if (cmd_ready && w_last_col && w_last_row) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_h0       <= '0;
            r_v0       <= '0;
            r_dh       <= '0;
            r_dv       <= '0;
            r_step_q_h <= '0;
            r_step_q_v <= '0;
            r_step_r_h <= '0;
            r_step_r_v <= '0;
            r_quot_h   <= '0;
            r_quot_v   <= '0;
            r_rem_h    <= '0;
            r_rem_v    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_h0       <= H0;
                        r_v0       <= V0;
                        r_dh       <= TW - 6'd1;
                        r_dv       <= TH - 6'd1;
                        r_step_q_h <= '0;
                        r_step_q_v <= '0;
                        r_step_r_h <= (TW == 6'd1) ? 6'd0 : {1'b0, SW - 5'd1};
                        r_step_r_v <= (TH == 6'd1) ? 6'd0 : {1'b0, SH - 5'd1};
                        r_quot_h   <= '0;
                        r_quot_v   <= '0;
                        r_rem_h    <= '0;
                        r_rem_v    <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_addr     <= '0;
                    end
                end
                S_PREP: begin
                    if (!w_fin_h) begin
                        r_step_r_h <= r_step_r_h - r_dh;
                        r_step_q_h <= r_step_q_h + 5'd1;
                    end
                    if (!w_fin_v) begin
                        r_step_r_v <= r_step_r_v - r_dv;
                        r_step_q_v <= r_step_q_v + 5'd1;
                    end
                end
                S_ISSUE: begin
                    if (w_hs) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_last_col) begin
                            r_col    <= '0;
                            r_quot_h <= '0;
                            r_rem_h  <= '0;
                            r_row    <= r_row + 6'd1;
                            r_rem_v  <= w_rem_v_nxt;
                            r_quot_v <= r_quot_v + COORD_W'(r_step_q_v) + COORD_W'(w_wrap_v);
                        end else begin
                            r_col    <= r_col + 6'd1;
                            r_rem_h  <= w_rem_h_nxt;
                            r_quot_h <= r_quot_h + COORD_W'(r_step_q_h) + COORD_W'(w_wrap_h);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign src_col     = r_h0 + r_quot_h;
    assign src_row     = r_v0 + r_quot_v;
    assign frac_h      = r_rem_h;
    assign frac_v      = r_rem_v;
    assign tgt_addr    = r_addr;
    assign row_first   = cmd_valid && (r_col == 6'd0);
    assign row_last    = cmd_valid && w_last_col;
    assign o_dbg_state = r_state;

endmodule
